// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg -- shared types and helpers for the load/store unit.
//   mem_size_e  : access size encoding carried on lsu_size_i (2'b11 is illegal)
//   lsu_state_e : load/store unit sequencing states
//   misaligned(): size/offset legality test
//   byte_enable(): byte-lane mask for an aligned access
// ---------------------------------------------------------------------------
package rv_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_e;

  // Illegal size 2'b11 is folded into the misaligned case so the core sees
  // a single exception flag.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    logic res;
    case (size)
      BYTE:    res = 1'b0;
      HALF:    res = off[0];
      WORD:    res = (off != 2'b00);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] res;
    case (size)
      BYTE:    res = 4'b0001 << off;
      HALF:    res = 4'b0011 << off;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv_signextend.sv
// ---------------------------------------------------------------------------
// rv_signextend -- replicates the MSB of in_data up to OUT_WIDTH bits.
//   in_data  [IN_WIDTH-1:0]  : value to extend
//   out_data [OUT_WIDTH-1:0] : sign-extended value
// ---------------------------------------------------------------------------
module rv_signextend #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic [OUT_WIDTH-1:0] out_data
);

  assign out_data = {{(OUT_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};

endmodule

// File: rtl/rv_lsu.sv
// ---------------------------------------------------------------------------
// rv_lsu -- single-outstanding load/store unit between the core pipeline and
// a grant/rvalid data memory port.
//   clk_i, arstn_i           : clock, asynchronous active-low reset
//   lsu_req_i .. lsu_wdata_i : core request (held stable while lsu_stall_o)
//   lsu_stall_o              : hold the core pipeline
//   lsu_done_o               : one-cycle completion pulse
//   lsu_misalign_o           : misaligned / illegal size, valid with done
//   lsu_rdata_o              : extended load data, valid with done
//   data_req_o .. data_wdata_o : memory request (payload zero when idle)
//   data_gnt_i, data_rvalid_i, data_rdata_i : memory grant / response
// ---------------------------------------------------------------------------
module rv_lsu (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        lsu_req_i,
  input  logic        lsu_we_i,
  input  logic [1:0]  lsu_size_i,
  input  logic        lsu_unsigned_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  output logic        lsu_stall_o,
  output logic        lsu_done_o,
  output logic        lsu_misalign_o,
  output logic [31:0] lsu_rdata_o,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i
);

  import rv_pkg::*;

  localparam logic [31:0] ZEXT8_MASK  = 32'h0000_00FF;
  localparam logic [31:0] ZEXT16_MASK = 32'h0000_FFFF;

  lsu_state_e  state_reg;
  logic        we_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [1:0]  off_reg;
  logic [29:0] waddr_reg;
  logic [3:0]  be_reg;
  logic [31:0] wdata_reg;
  logic        misalign_reg;
  logic [31:0] rdata_reg;

  logic        req_misaligned;
  logic [31:0] wdata_rep;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] byte_ext;
  logic [31:0] half_ext;
  logic [31:0] load_ext;

  assign req_misaligned = misaligned(lsu_size_i, lsu_addr_i[1:0]);

  // Store data replicated across all lanes so the memory only needs be.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wdata_rep[8*gi +: 8] =
        (lsu_size_i == BYTE) ? lsu_wdata_i[7:0] :
        (lsu_size_i == HALF) ? lsu_wdata_i[8*(gi%2) +: 8] :
                               lsu_wdata_i[8*gi +: 8];
    end
  endgenerate

  // Load lane extraction from the latched byte offset.
  assign byte_sel = data_rdata_i[{off_reg, 3'b000} +: 8];
  assign half_sel = data_rdata_i[{off_reg[1], 4'b0000} +: 16];

  rv_signextend #(.IN_WIDTH(8), .OUT_WIDTH(32)) u_sext_byte (
    .in_data  (byte_sel),
    .out_data (byte_ext)
  );

  rv_signextend #(.IN_WIDTH(16), .OUT_WIDTH(32)) u_sext_half (
    .in_data  (half_sel),
    .out_data (half_ext)
  );

  // Unsigned loads reuse the sign-extended value and mask off the upper bits.
  always_comb begin
    load_ext = data_rdata_i;
    case (size_reg)
      BYTE:    load_ext = uns_reg ? (byte_ext & ZEXT8_MASK)  : byte_ext;
      HALF:    load_ext = uns_reg ? (half_ext & ZEXT16_MASK) : half_ext;
      default: load_ext = data_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_reg    <= IDLE;
      we_reg       <= 1'b0;
      size_reg     <= 2'b00;
      uns_reg      <= 1'b0;
      off_reg      <= 2'b00;
      waddr_reg    <= '0;
      be_reg       <= '0;
      wdata_reg    <= '0;
      misalign_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (lsu_req_i) begin
            misalign_reg <= req_misaligned;
            rdata_reg    <= '0;
            if (req_misaligned) begin
              state_reg <= DONE;
            end else begin
              we_reg    <= lsu_we_i;
              size_reg  <= lsu_size_i;
              uns_reg   <= lsu_unsigned_i;
              off_reg   <= lsu_addr_i[1:0];
              waddr_reg <= lsu_addr_i[31:2];
              be_reg    <= byte_enable(lsu_size_i, lsu_addr_i[1:0]);
              wdata_reg <= wdata_rep;
              state_reg <= REQ;
            end
          end
        end
        REQ: begin
          if (data_gnt_i) state_reg <= RESP;
        end
        RESP: begin
          // Stores also wait for the write response but keep rdata at zero.
          if (data_rvalid_i) begin
            if (!we_reg) rdata_reg <= load_ext;
            state_reg <= DONE;
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign data_req_o   = (state_reg == REQ);
  assign data_we_o    = data_req_o & we_reg;
  assign data_be_o    = data_req_o ? be_reg : 4'b0000;
  assign data_addr_o  = data_req_o ? {waddr_reg, 2'b00} : 32'h0;
  assign data_wdata_o = data_req_o ? wdata_reg : 32'h0;

  assign lsu_done_o     = (state_reg == DONE);
  assign lsu_misalign_o = lsu_done_o & misalign_reg;
  assign lsu_rdata_o    = lsu_done_o ? rdata_reg : 32'h0;

  // The reset term keeps stall low while reset is held even if the core
  // is still presenting a request.
  assign lsu_stall_o = arstn_i & ((state_reg == REQ) || (state_reg == RESP) ||
                                  ((state_reg == IDLE) && lsu_req_i));

endmodule

// File: tb/tb_rv_lsu.sv
module tb_rv_lsu;

  logic        clk_i = 1'b0;
  logic        arstn_i;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_unsigned_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic        lsu_stall_o;
  logic        lsu_done_o;
  logic        lsu_misalign_o;
  logic [31:0] lsu_rdata_o;
  logic        data_req_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;

  int checks = 0;
  int errors = 0;
  int txn_id = 0;

  always #5 clk_i = ~clk_i;

  rv_lsu dut (
    .clk_i          (clk_i),
    .arstn_i        (arstn_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_unsigned_i (lsu_unsigned_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_stall_o    (lsu_stall_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_misalign_o (lsu_misalign_o),
    .lsu_rdata_o    (lsu_rdata_o),
    .data_req_o     (data_req_o),
    .data_we_o      (data_we_o),
    .data_be_o      (data_be_o),
    .data_addr_o    (data_addr_o),
    .data_wdata_o   (data_wdata_o),
    .data_gnt_i     (data_gnt_i),
    .data_rvalid_i  (data_rvalid_i),
    .data_rdata_i   (data_rdata_i)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] eaddr;
    logic [31:0] ewdata;
    logic [31:0] erdata;
    logic        mis;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL txn%0d %s: got %h expected %h", txn_id, name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},    32'(lsu_stall_o),    32'd0);
    check({tag, "_done"},     32'(lsu_done_o),     32'd0);
    check({tag, "_misalign"}, 32'(lsu_misalign_o), 32'd0);
    check({tag, "_rdata"},    lsu_rdata_o,         32'd0);
    check({tag, "_req"},      32'(data_req_o),     32'd0);
    check({tag, "_we"},       32'(data_we_o),      32'd0);
    check({tag, "_be"},       32'(data_be_o),      32'd0);
    check({tag, "_addr"},     data_addr_o,         32'd0);
    check({tag, "_wdata"},    data_wdata_o,        32'd0);
  endtask

  // Reference model: arithmetic on access width in bytes.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                       output logic [3:0] be, output logic [31:0] a, output logic [31:0] w,
                       output logic [31:0] r, output logic mis);
    int          nb;
    int          off;
    logic [31:0] tmp;
    logic [31:0] mask;
    logic [31:0] val;
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off = int'(addr % 4);
    mis = (size == 2'd3) || ((addr % nb) != 0);
    a   = addr - (addr % 4);
    tmp = ((32'd1 << nb) - 32'd1) << off;
    be  = tmp[3:0];
    if (nb == 1)      w = {24'd0, wdata[7:0]} * 32'h0101_0101;
    else if (nb == 2) w = {16'd0, wdata[15:0]} * 32'h0001_0001;
    else              w = wdata;
    mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
    val  = (rdata >> (8*off)) & mask;
    if (!uns && nb < 4 && val[8*nb-1]) val = val | ~mask;
    r = (we || mis) ? 32'd0 : val;
    if (mis) begin
      be = 4'd0; a = 32'd0; w = 32'd0;
    end
  endtask

  // Entered at a negedge: either in an IDLE cycle (b2b=0) or in the DONE
  // cycle of the previous access (b2b=1). Returns at the negedge of DONE.
  task automatic access(input bit b2b, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                        input int gd, input int rd,
                        input logic [3:0] e_be, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                        input logic [31:0] e_rdata, input logic e_mis);
    int done_k;
    bit rq;
    txn_id++;
    lsu_req_i      = 1'b1;
    lsu_we_i       = we;
    lsu_size_i     = size;
    lsu_unsigned_i = uns;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wdata;
    if (b2b) begin
      #1;
      check("stall_in_done", 32'(lsu_stall_o), 32'd0);
      @(negedge clk_i);
    end
    data_gnt_i    = 1'($urandom_range(0, 1));
    data_rvalid_i = 1'($urandom_range(0, 1));
    data_rdata_i  = $urandom;
    #1;
    check("stall_accept", 32'(lsu_stall_o), 32'd1);
    check("req_accept",   32'(data_req_o),  32'd0);
    done_k = e_mis ? 1 : 3 + gd + rd;
    for (int k = 1; k <= done_k; k++) begin
      @(negedge clk_i);
      rq = !e_mis && (k <= 1 + gd);
      check("data_req",   32'(data_req_o), 32'(rq));
      check("data_we",    32'(data_we_o),  rq ? 32'(we) : 32'd0);
      check("data_be",    32'(data_be_o),  rq ? 32'(e_be) : 32'd0);
      check("data_addr",  data_addr_o,     rq ? e_addr : 32'd0);
      check("data_wdata", data_wdata_o,    rq ? e_wdata : 32'd0);
      check("stall",      32'(lsu_stall_o), 32'(k < done_k));
      check("done",       32'(lsu_done_o),  32'(k == done_k));
      if (k == done_k) begin
        check("misalign", 32'(lsu_misalign_o), 32'(e_mis));
        check("rdata",    lsu_rdata_o,         e_rdata);
      end
      if (e_mis) begin
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
      end else if (k <= 1 + gd) begin
        data_gnt_i    = (k == 1 + gd);
        data_rvalid_i = 1'($urandom_range(0, 1));
        data_rdata_i  = $urandom;
      end else begin
        data_gnt_i    = 1'($urandom_range(0, 1));
        data_rvalid_i = (k == 2 + gd + rd);
        data_rdata_i  = data_rvalid_i ? rdata : $urandom;
      end
    end
    lsu_req_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    $display("txn %0d we=%0d size=%0d uns=%0d addr=%h gd=%0d rd=%0d rdata=%h mis=%0d",
             txn_id, we, size, uns, addr, gd, rd, lsu_rdata_o, lsu_misalign_o);
  endtask

  task automatic idle_gap();
    @(negedge clk_i);
    check("stall_idle", 32'(lsu_stall_o), 32'd0);
  endtask

  initial begin
    logic [3:0]  m_be;
    logic [31:0] m_a, m_w, m_r;
    logic        m_mis;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rdata;
    int          r_gd, r_rd;
    bit          r_b2b;

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_1234, 4'b1000, 32'h0000_1000, 32'h0, 32'hFFFF_FF80, 1'b0};
    vecs[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 4'b1000, 32'h0000_1000, 32'h0, 32'h0000_0080, 1'b0};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 4'b1100, 32'h0000_2000, 32'h0, 32'hFFFF_8001, 1'b0};
    vecs[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 4'b1100, 32'h0000_2000, 32'h0, 32'h0000_8001, 1'b0};
    vecs[4]  = '{1'b1, 2'd0, 1'b0, 32'h0000_3001, 32'h0000_00AB, 32'hDEAD_BEEF, 4'b0010, 32'h0000_3000, 32'hABAB_ABAB, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 32'h1111_1111, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[6]  = '{1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h1234_5678, 4'b1111, 32'h0000_5000, 32'h0, 32'h1234_5678, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 32'h2222_2222, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h3333_3333, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{1'b1, 2'd1, 1'b0, 32'h0000_6002, 32'h1234_BEEF, 32'h4444_4444, 4'b1100, 32'h0000_6000, 32'hBEEF_BEEF, 32'h0, 1'b0};
    vecs[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_7004, 32'hCAFE_F00D, 32'h5555_5555, 4'b1111, 32'h0000_7004, 32'hCAFE_F00D, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h0000_0000, 32'h0, 32'h0000_007F, 4'b0001, 32'h0000_0000, 32'h0, 32'h0000_007F, 1'b0};
    vecs[12] = '{1'b0, 2'd0, 1'b0, 32'h0000_9001, 32'h0, 32'h0000_FF00, 4'b0010, 32'h0000_9000, 32'h0, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 1'b0, 32'h0000_A000, 32'h0, 32'h1234_F00F, 4'b0011, 32'h0000_A000, 32'h0, 32'hFFFF_F00F, 1'b0};

    // Reset held with a request pending: everything must stay at zero.
    arstn_i        = 1'b0;
    lsu_req_i      = 1'b1;
    lsu_we_i       = 1'b1;
    lsu_size_i     = 2'd2;
    lsu_unsigned_i = 1'b0;
    lsu_addr_i     = 32'h0000_0100;
    lsu_wdata_i    = 32'hFFFF_FFFF;
    data_gnt_i     = 1'b1;
    data_rvalid_i  = 1'b1;
    data_rdata_i   = 32'hFFFF_FFFF;
    #2;
    check_all_zero("reset");
    @(negedge clk_i);
    lsu_req_i     = 1'b0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    arstn_i       = 1'b1;

    // Directed vectors at minimum latency.
    for (int i = 0; i < 14; i++) begin
      idle_gap();
      access(1'b0, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
             vecs[i].rdata, 0, 0, vecs[i].be, vecs[i].eaddr, vecs[i].ewdata, vecs[i].erdata,
             vecs[i].mis);
    end

    // Grant held off 3 cycles, then a back-to-back load right after DONE.
    idle_gap();
    access(1'b0, 1'b0, 2'd2, 1'b0, 32'h0000_8000, 32'h0, 32'hA5A5_0F0F, 3, 1,
           4'b1111, 32'h0000_8000, 32'h0, 32'hA5A5_0F0F, 1'b0);
    access(1'b1, 1'b0, 2'd1, 1'b1, 32'h0000_8006, 32'h0, 32'hBEEF_0000, 0, 2,
           4'b1100, 32'h0000_8004, 32'h0, 32'h0000_BEEF, 1'b0);

    // Reset asserted while the load is waiting for rvalid.
    idle_gap();
    txn_id++;
    lsu_req_i  = 1'b1;
    lsu_we_i   = 1'b0;
    lsu_size_i = 2'd2;
    lsu_addr_i = 32'h0000_0C00;
    data_gnt_i = 1'b0;
    @(negedge clk_i);
    check("rst_seq_req", 32'(data_req_o), 32'd1);
    data_gnt_i = 1'b1;
    @(negedge clk_i);
    data_gnt_i = 1'b0;
    check("rst_seq_resp_stall", 32'(lsu_stall_o), 32'd1);
    check("rst_seq_resp_req",   32'(data_req_o),  32'd0);
    arstn_i = 1'b0;
    #1;
    check_all_zero("midrst");
    lsu_req_i = 1'b0;
    @(negedge clk_i);
    arstn_i       = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h1234_5678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      check("late_rvalid_done",  32'(lsu_done_o),  32'd0);
      check("late_rvalid_stall", 32'(lsu_stall_o), 32'd0);
      check("late_rvalid_req",   32'(data_req_o),  32'd0);
    end
    data_rvalid_i = 1'b0;
    $display("txn %0d reset during RESP, late rvalid ignored", txn_id);
    idle_gap();
    access(1'b0, 1'b1, 2'd0, 1'b0, 32'h0000_0D02, 32'h0000_005A, 32'h0, 0, 0,
           4'b0100, 32'h0000_0D00, 32'h5A5A_5A5A, 32'h0, 1'b0);

    // Randomised accesses against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_uns   = 1'($urandom_range(0, 1));
      r_size  = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr  = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        if (r_size == 2'd1) r_addr[0] = 1'b0;
        if (r_size == 2'd2) r_addr[1:0] = 2'b00;
      end
      r_wdata = $urandom;
      r_rdata = $urandom;
      r_gd    = int'($urandom_range(0, 3));
      r_rd    = int'($urandom_range(0, 3));
      r_b2b   = ($urandom_range(0, 1) == 1);
      model(r_we, r_size, r_uns, r_addr, r_wdata, r_rdata, m_be, m_a, m_w, m_r, m_mis);
      if (!r_b2b) idle_gap();
      access(r_b2b, r_we, r_size, r_uns, r_addr, r_wdata, r_rdata, r_gd, r_rd,
             m_be, m_a, m_w, m_r, m_mis);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
